// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encodings for the 1010 detector and its window monitor
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } det_state_e;

endpackage

// File: rtl/seq_det_window_monitor_if.sv
// rtl/seq_det_window_monitor_if.sv - one-deep window report slot (valid/ready)
interface seq_det_window_monitor_if #(
  parameter int CW = 5
);
  logic [CW-1:0] Cnt;
  logic          Vld;
  logic          Alarm;
  logic          Rdy;

  modport master (output Cnt, output Vld, output Alarm, input Rdy);
  modport slave  (input Cnt, input Vld, input Alarm, output Rdy);
endinterface

// File: rtl/seq_det_window_monitor_sat_counter.sv
// rtl/seq_det_window_monitor_sat_counter.sv - saturating up-counter with clear and increment enable
module sat_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  assign sat = &q;

  // clear wins over increment so a window close can restart from zero
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_det_window_monitor.sv
// rtl/seq_det_window_monitor.sv - counts detector pulses per WIN-cycle window and reports them
module seq_det_window_monitor
  import seq_det_pkg::*;
#(
  parameter int WIN    = 16,
  parameter int CW     = 5,
  parameter int THRESH = 3
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       En,
  input  logic                       Det,
  seq_det_window_monitor_if.master   rpt,
  output logic                       Ovf,
  output logic [1:0]                 Sta
);

  localparam int            WW   = $clog2(WIN);
  localparam logic [WW-1:0] LAST = WW'(WIN - 1);

  mon_state_e    state;
  logic [WW-1:0] wctr;
  logic [CW-1:0] acc;
  logic [CW-1:0] fin;
  logic [CW-1:0] cnt_q;
  logic          acc_sat;
  logic          vld_q;
  logic          alarm_q;
  logic          ovf_q;
  logic          close;
  logic          slot_free;
  logic          acc_clr;
  logic          acc_inc;

  assign close     = (wctr == LAST);
  assign slot_free = !vld_q || rpt.Rdy;
  assign fin       = (Det && !acc_sat) ? acc + CW'(1) : acc;

  // acc takes the closing sample even when the slot is busy, so WAIT holds the full count
  always_comb begin
    acc_clr = 1'b0;
    acc_inc = 1'b0;
    case (state)
      ST_RUN: begin
        acc_inc = En && Det;
        acc_clr = En && close && slot_free;
      end
      ST_WAIT: acc_clr = En && vld_q && rpt.Rdy;
      default: acc_clr = 1'b1;
    endcase
  end

  sat_counter #(.W(CW)) u_acc (
    .Clk (Clk),
    .Rst (Rst),
    .clr (acc_clr),
    .inc (acc_inc),
    .q   (acc),
    .sat (acc_sat)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      wctr    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (vld_q && rpt.Rdy) vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (En) begin
            state <= ST_RUN;
            wctr  <= '0;
          end
        end
        ST_RUN: begin
          if (!En) begin
            state <= ST_IDLE;
          end else if (close) begin
            if (slot_free) begin
              cnt_q   <= fin;
              alarm_q <= (int'(fin) >= THRESH);
              vld_q   <= 1'b1;
              wctr    <= '0;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            wctr <= wctr + WW'(1);
          end
        end
        ST_WAIT: begin
          if (!En) begin
            state <= ST_IDLE;
          end else begin
            if (Det) ovf_q <= 1'b1;
            if (vld_q && rpt.Rdy) begin
              cnt_q   <= acc;
              alarm_q <= (int'(acc) >= THRESH);
              vld_q   <= 1'b1;
              wctr    <= '0;
              state   <= ST_RUN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rpt.Cnt   = cnt_q;
  assign rpt.Vld   = vld_q;
  assign rpt.Alarm = alarm_q;
  assign Ovf       = ovf_q;
  assign Sta       = state;

endmodule

// File: tb/tb_seq_det_window_monitor.sv
// tb/tb_seq_det_window_monitor.sv - directed scoreboard bench for the detector window monitor
module tb_seq_det_window_monitor;
  import seq_det_pkg::*;

  typedef struct packed {
    logic [3:0] cnt;
    logic       alarm;
  } rpt_t;

  logic       Clk;
  logic       Rst;
  logic       En, Det;
  logic       En_s, Det_s;
  logic       Ovf, Ovf_s;
  logic [1:0] Sta, Sta_s;

  int   checks   = 0;
  int   failures = 0;
  rpt_t sb_q[$];

  seq_det_window_monitor_if #(.CW(4)) if_a ();
  seq_det_window_monitor_if #(.CW(4)) if_s ();

  seq_det_window_monitor #(.WIN(8), .CW(4), .THRESH(2)) dut (
    .Clk (Clk), .Rst (Rst), .En (En), .Det (Det),
    .rpt (if_a), .Ovf (Ovf), .Sta (Sta)
  );

  seq_det_window_monitor #(.WIN(24), .CW(4), .THRESH(2)) dut_s (
    .Clk (Clk), .Rst (Rst), .En (En_s), .Det (Det_s),
    .rpt (if_s), .Ovf (Ovf_s), .Sta (Sta_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // a transfer happens at the coming edge; compare against the oldest expected report
  always @(negedge Clk) begin
    if (Rst === 1'b0 && if_a.Vld === 1'b1 && if_a.Rdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_report", 32'd1, 32'd0);
      end else begin
        rpt_t e;
        e = sb_q.pop_front();
        chk("sb_cnt", 32'(if_a.Cnt), 32'(e.cnt));
        chk("sb_alarm", 32'(if_a.Alarm), 32'(e.alarm));
      end
    end
  end

  initial begin
    Rst = 1'b1; En = 1'b1; Det = 1'b0; if_a.Rdy = 1'b0;
    En_s = 1'b0; Det_s = 1'b0; if_s.Rdy = 1'b0;

    // reset with En and Det active
    for (int i = 0; i < 2; i++) begin
      Det = ~Det;
      tick();
    end
    chk("rst_cnt", 32'(if_a.Cnt), 32'd0);
    chk("rst_vld", 32'(if_a.Vld), 32'd0);
    chk("rst_alarm", 32'(if_a.Alarm), 32'd0);
    chk("rst_ovf", 32'(Ovf), 32'd0);
    chk("rst_sta", 32'(Sta), 32'(ST_IDLE));
    Rst = 1'b0; Det = 1'b0; if_a.Rdy = 1'b1;
    tick();
    chk("run_after_rst", 32'(Sta), 32'(ST_RUN));

    // basic window: pulses at 1, 4, 7
    sb_q.push_back('{cnt: 4'd3, alarm: 1'b1});
    for (int i = 0; i < 8; i++) begin
      Det = (i == 1 || i == 4 || i == 7);
      tick();
      if (i == 6) chk("w1_vld_before_close", 32'(if_a.Vld), 32'd0);
    end
    Det = 1'b0;
    chk("w1_vld", 32'(if_a.Vld), 32'd1);
    chk("w1_cnt", 32'(if_a.Cnt), 32'd3);
    chk("w1_alarm", 32'(if_a.Alarm), 32'd1);

    sb_q.push_back('{cnt: 4'd0, alarm: 1'b0});
    for (int i = 0; i < 8; i++) tick();
    chk("w2_vld", 32'(if_a.Vld), 32'd1);
    chk("w2_cnt", 32'(if_a.Cnt), 32'd0);
    chk("w2_alarm", 32'(if_a.Alarm), 32'd0);

    // backpressure across two closes
    sb_q.push_back('{cnt: 4'd2, alarm: 1'b1});
    for (int i = 0; i < 8; i++) begin
      if_a.Rdy = (i == 0);
      Det = (i == 2 || i == 5);
      tick();
    end
    chk("w3_cnt", 32'(if_a.Cnt), 32'd2);
    sb_q.push_back('{cnt: 4'd4, alarm: 1'b1});
    for (int i = 0; i < 8; i++) begin
      Det = (i % 2 == 0);
      tick();
    end
    Det = 1'b0;
    chk("bp_sta_wait", 32'(Sta), 32'(ST_WAIT));
    chk("bp_cnt_hold", 32'(if_a.Cnt), 32'd2);
    chk("bp_vld", 32'(if_a.Vld), 32'd1);
    chk("bp_ovf_clear", 32'(Ovf), 32'd0);
    Det = 1'b1;
    tick();
    Det = 1'b0;
    tick();
    chk("bp_ovf_set", 32'(Ovf), 32'd1);
    chk("bp_still_wait", 32'(Sta), 32'(ST_WAIT));
    chk("bp_cnt_stable", 32'(if_a.Cnt), 32'd2);
    if_a.Rdy = 1'b1;
    tick();
    chk("bp_release_cnt", 32'(if_a.Cnt), 32'd4);
    chk("bp_release_vld", 32'(if_a.Vld), 32'd1);
    chk("bp_release_sta", 32'(Sta), 32'(ST_RUN));

    // full-length window after WAIT: boundary samples 0 and 7
    sb_q.push_back('{cnt: 4'd2, alarm: 1'b1});
    for (int i = 0; i < 8; i++) begin
      Det = (i == 0 || i == 7);
      tick();
    end
    Det = 1'b0;
    chk("w5_cnt", 32'(if_a.Cnt), 32'd2);
    chk("w5_vld", 32'(if_a.Vld), 32'd1);

    // transfer exactly at the close edge: no bubble
    sb_q.push_back('{cnt: 4'd1, alarm: 1'b0});
    for (int i = 0; i < 8; i++) begin
      if_a.Rdy = (i == 7);
      Det = (i == 3);
      tick();
      chk($sformatf("w6_vld_c%0d", i), 32'(if_a.Vld), 32'd1);
    end
    Det = 1'b0;
    chk("w6_cnt", 32'(if_a.Cnt), 32'd1);
    chk("w6_alarm", 32'(if_a.Alarm), 32'd0);
    chk("w6_sta", 32'(Sta), 32'(ST_RUN));

    // abort at window cycle 5 with acc = 2
    for (int i = 0; i < 5; i++) begin
      Det = (i == 1 || i == 3);
      tick();
    end
    En = 1'b0; Det = 1'b0;
    tick();
    chk("abort_sta", 32'(Sta), 32'(ST_IDLE));
    Det = 1'b1;
    tick();
    chk("abort_no_report", 32'(if_a.Vld), 32'd0);
    En = 1'b1; Det = 1'b0;
    tick();
    chk("abort_rerun", 32'(Sta), 32'(ST_RUN));
    sb_q.push_back('{cnt: 4'd1, alarm: 1'b0});
    for (int i = 0; i < 8; i++) begin
      Det = (i == 6);
      tick();
    end
    Det = 1'b0;
    chk("w8_cnt", 32'(if_a.Cnt), 32'd1);
    chk("w8_vld", 32'(if_a.Vld), 32'd1);
    chk("ovf_sticky", 32'(Ovf), 32'd1);

    // illegal state recovers to IDLE
    force dut.state = mon_state_e'(2'd3);
    release dut.state;
    tick();
    chk("illegal_to_idle", 32'(Sta), 32'(ST_IDLE));
    tick();
    chk("illegal_rerun", 32'(Sta), 32'(ST_RUN));
    En = 1'b0;
    tick();
    tick();

    // saturation on the WIN=24 instance
    En_s = 1'b1; if_s.Rdy = 1'b1;
    tick();
    chk("sat_run", 32'(Sta_s), 32'(ST_RUN));
    for (int i = 0; i < 24; i++) begin
      Det_s = (i < 20);
      tick();
      if (i == 22) chk("sat_vld_before_close", 32'(if_s.Vld), 32'd0);
    end
    Det_s = 1'b0;
    chk("sat_vld", 32'(if_s.Vld), 32'd1);
    chk("sat_cnt", 32'(if_s.Cnt), 32'd15);
    chk("sat_alarm", 32'(if_s.Alarm), 32'd1);
    chk("sat_ovf", 32'(Ovf_s), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("final_vld", 32'(if_a.Vld), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
